// File: rtl/fft_pkg.sv
// Shared types for the FFT post-processing blocks: magnitude type and peak-detector FSM states.
`default_nettype none

package fft_pkg;

  localparam int MAG_W = 16;

  typedef logic [MAG_W-1:0] mag_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    STALL = 2'd2
  } peak_state_e;

endpackage

`default_nettype wire

// File: rtl/fft_peak_detect_if.sv
// Magnitude-stream input and frame-result output bundle of fft_peak_detect.
// Optional threshold ports exist only when FFT_PEAK_THRESH_EN is defined.
`default_nettype none

interface fft_peak_detect_if
  import fft_pkg::*;
#(
  parameter int N_BINS = 64,
  parameter int BIN_W  = $clog2(N_BINS),
  parameter int SUM_W  = 16 + BIN_W
);

  mag_t             mag_in;
  logic             in_valid;
  logic             in_ready;
  logic             frame_start;
  mag_t             peak_mag;
  logic [BIN_W-1:0] peak_bin;
  logic [SUM_W-1:0] frame_sum;
  logic             out_valid;
  logic             out_ready;
  logic             overrun;
`ifdef FFT_PEAK_THRESH_EN
  mag_t             peak_thresh;
  logic             peak_found;
`endif

  modport master (
`ifdef FFT_PEAK_THRESH_EN
    output peak_thresh,
    input  peak_found,
`endif
    output mag_in, in_valid, frame_start, out_ready,
    input  in_ready, peak_mag, peak_bin, frame_sum, out_valid, overrun
  );

  modport slave (
`ifdef FFT_PEAK_THRESH_EN
    input  peak_thresh,
    output peak_found,
`endif
    input  mag_in, in_valid, frame_start, out_ready,
    output in_ready, peak_mag, peak_bin, frame_sum, out_valid, overrun
  );

endinterface

`default_nettype wire

// File: rtl/fft_max_track.sv
// Running maximum / bin-index tracker; strict greater-than so the earliest bin wins a tie.
`default_nettype none

module fft_max_track
  import fft_pkg::*;
#(
  parameter int BIN_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             first,
  input  mag_t             mag,
  input  logic [BIN_W-1:0] bin,
  output mag_t             nxt_max,
  output logic [BIN_W-1:0] nxt_bin
);

  mag_t             acc_max;
  logic [BIN_W-1:0] acc_bin;

  // nxt_* already include the current beat so the top can capture the final compare directly
  always_comb begin
    nxt_max = acc_max;
    nxt_bin = acc_bin;
    if (first) begin
      nxt_max = mag;
      nxt_bin = '0;
    end else if (mag > acc_max) begin
      nxt_max = mag;
      nxt_bin = bin;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_max <= '0;
      acc_bin <= '0;
    end else if (en) begin
      acc_max <= nxt_max;
      acc_bin <= nxt_bin;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fft_peak_detect.sv
// Per-frame peak magnitude/bin and magnitude sum with a valid/ready result register.
// Optional FFT_PEAK_THRESH_EN adds peak_thresh/peak_found.
`default_nettype none

module fft_peak_detect
  import fft_pkg::*;
#(
  parameter int N_BINS = 64,
  parameter int BIN_W  = $clog2(N_BINS),
  parameter int SUM_W  = 16 + BIN_W
) (
  input logic              clk,
  input logic              rst_n,
  fft_peak_detect_if.slave bus
);

  localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(N_BINS - 1);

  peak_state_e      state, state_nxt;
  logic [BIN_W-1:0] bin_cnt;
  logic [BIN_W-1:0] cur_bin;
  logic [SUM_W-1:0] acc_sum;
  logic [SUM_W-1:0] nxt_sum;
  mag_t             nxt_max;
  logic [BIN_W-1:0] nxt_bin;
  logic             stall;
  logic             accept;
  logic             first;
  logic             complete;

  mag_t             peak_mag_r;
  logic [BIN_W-1:0] peak_bin_r;
  logic [SUM_W-1:0] frame_sum_r;
  logic             out_valid_r;
  logic             overrun_r;

  // Only the last bin can stall: it is the one beat that would overwrite an unconsumed result
  assign stall    = out_valid_r && !bus.out_ready && (bin_cnt == LAST_BIN);
  assign accept   = bus.in_valid && !stall;
  assign cur_bin  = bus.frame_start ? '0 : bin_cnt;
  assign first    = (cur_bin == '0);
  assign complete = accept && (cur_bin == LAST_BIN);
  assign nxt_sum  = first ? SUM_W'(bus.mag_in) : acc_sum + SUM_W'(bus.mag_in);

  assign bus.in_ready  = !stall;
  assign bus.peak_mag  = peak_mag_r;
  assign bus.peak_bin  = peak_bin_r;
  assign bus.frame_sum = frame_sum_r;
  assign bus.out_valid = out_valid_r;
  assign bus.overrun   = overrun_r;

  fft_max_track #(
    .BIN_W (BIN_W)
  ) u_max_track (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (accept),
    .first   (first),
    .mag     (bus.mag_in),
    .bin     (cur_bin),
    .nxt_max (nxt_max),
    .nxt_bin (nxt_bin)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_cnt <= '0;
      acc_sum <= '0;
    end else if (accept) begin
      bin_cnt <= cur_bin + 1'b1;
      acc_sum <= nxt_sum;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak_mag_r  <= '0;
      peak_bin_r  <= '0;
      frame_sum_r <= '0;
      out_valid_r <= 1'b0;
    end else if (complete) begin
      peak_mag_r  <= nxt_max;
      peak_bin_r  <= nxt_bin;
      frame_sum_r <= nxt_sum;
      out_valid_r <= 1'b1;
    end else if (bus.out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_r <= 1'b0;
    end else if (stall && bus.in_valid) begin
      overrun_r <= 1'b1;
    end
  end

`ifdef FFT_PEAK_THRESH_EN
  logic peak_found_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak_found_r <= 1'b0;
    end else if (complete) begin
      peak_found_r <= (nxt_max >= bus.peak_thresh);
    end
  end

  assign bus.peak_found = peak_found_r;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (stall) state_nxt = STALL; else if (accept) state_nxt = SCAN;
      SCAN:    if (stall) state_nxt = STALL;
      STALL:   if (!stall) state_nxt = SCAN;
      default: state_nxt = IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: doc/fft_peak_detect.md
# fft_peak_detect

- Consumes the per-bin 16-bit magnitude stream produced by the FFT magnitude stage.
- Scans each frame of `N_BINS` bins and reports, per frame:
  - the peak magnitude and its bin index;
  - the frame sum of magnitudes.
- The result is held in an output register that is double-buffered against the next frame's scan, and is handed to the downstream spectral-decision logic through a valid/ready handshake.

## Interface
Parameters:
- `N_BINS`, 64: bins per frame; power of two, ≥ 2.
- `BIN_W`, $clog2(N_BINS): bin index width.
- `SUM_W`, 16+BIN_W: frame sum width; the sum cannot overflow.

Ports:
- `clk`  in  1  sole clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `mag_in`  in  16  unsigned magnitude of the current bin.
- `in_valid`  in  1  `mag_in` is valid this cycle.
- `in_ready`  out  1  block accepts `mag_in` this cycle.
- `frame_start`  in  1  qualified by `in_valid`; marks bin 0 and resynchronises the bin counter.
- `peak_mag`  out  16  largest magnitude in the last completed frame.
- `peak_bin`  out  BIN_W  bin index of `peak_mag`.
- `frame_sum`  out  SUM_W  sum of all magnitudes in the frame.
- `out_valid`  out  1  result registers hold an unconsumed frame result.
- `out_ready`  in  1  downstream accepts the result.
- `overrun`  out  1  sticky; set when a frame completes while the previous result is still unconsumed.
- `peak_thresh`  in  16  present only with `FFT_PEAK_THRESH_EN`.
- `peak_found`  out  1  present only with `FFT_PEAK_THRESH_EN`.

## Operation
- A beat is accepted when `in_valid && in_ready`.
- Bin counter `bin_cnt`:
  - increments on every accepted beat and wraps from `N_BINS-1` to 0;
  - an accepted beat with `frame_start=1` forces this beat to bin 0 and discards the partial accumulation;
  - `frame_start` on a beat that is already bin 0 is a no-op.
- Accumulators: `acc_max`, `acc_bin`, `acc_sum`.
  - Bin 0 loads `acc_max=mag_in`, `acc_bin=0`, `acc_sum=mag_in`.
  - Later bins add `mag_in` into `acc_sum`.
  - Later bins replace `acc_max`/`acc_bin` only if `mag_in > acc_max` (strict). On a tie the earliest bin wins.
- Frame completion on the accepted beat with `bin_cnt==N_BINS-1`:
  - the final compare and sum, including this beat, are loaded into `peak_mag`/`peak_bin`/`frame_sum`;
  - `out_valid` is set.
- Output handshake:
  - the result is consumed on `out_valid && out_ready`, which clears `out_valid`;
  - while `out_valid=1` the outputs are stable.
- Backpressure and overrun:
  - `in_ready = !(out_valid && !out_ready && bin_cnt==N_BINS-1)`, so only the last bin of a frame can stall;
  - `overrun` is set on any cycle where that stall condition holds with `in_valid=1`;
  - `overrun` is cleared only by reset.
- Simultaneous consume and completion: the new result loads, and `out_valid` stays 1.
- Control FSM:
  - `IDLE`: after reset, until the first accepted beat;
  - `SCAN`: after any accepted beat, when not in `STALL`;
  - `STALL`: while the `in_ready=0` condition holds;
  - `STALL` → `SCAN` when the condition clears.
- Arithmetic: all values are unsigned; the sum is zero-extended to `SUM_W`.

## Timing
- Reset values: `peak_mag=0`, `peak_bin=0`, `frame_sum=0`, `out_valid=0`, `overrun=0`, `in_ready=1`, `peak_found=0`; `bin_cnt=0`; state `IDLE`.
- `in_ready` is combinational from `out_valid`, `out_ready` and `bin_cnt`.
- All other outputs are registered.
- Latency: the results appear, with `out_valid=1`, in the cycle after the last bin is accepted.
- Reset asserted mid-frame: the partial frame is lost; the first beat after reset is bin 0.
- Throughput: one bin per cycle when `out_ready` is held high.

## Configuration
`FFT_PEAK_THRESH_EN`

Defined:
- adds `peak_thresh` and `peak_found`;
- `peak_found` is registered with the result and equals `peak_mag >= peak_thresh`, sampled on the completing beat.

Undefined:
- neither port exists;
- no compare logic is built.

## Structure
- Shared package `fft_pkg`:
  - `MAG_W=16` and `mag_t` (logic [15:0]);
  - the `peak_state_e` enum (`IDLE`, `SCAN`, `STALL`).
- One sub-module, `fft_max_track`. It holds the running max/index compare-and-update, which keeps the tie rule in one place.
- Counter, sum, handshake and FSM live in the top.

## Test plan
All scenarios use `N_BINS=8`.
- Ramp: mags 1..8 with `out_ready=1` → `peak_mag=8`, `peak_bin=7`, `frame_sum=36`; `out_valid` pulses for 1 cycle, one cycle after the 8th beat.
- Tie: mags {5,9,3,9,0,0,0,0} → `peak_mag=9`, `peak_bin=1`, `frame_sum=26`.
- Backpressure:
  - `out_ready=0` after frame 1; stream frame 2 → `in_ready=0` on frame 2's bin 7, `overrun=1`, frame 1 result held stable;
  - then raise `out_ready` → frame 2 result loads the following cycle.
- Resync: 3 beats, then `frame_start=1` with mags 2,2,2,2,2,2,2,2 → `frame_sum=16`, `peak_bin=0`.
- Reset mid-frame: assert `rst_n=0` after 4 beats → all outputs return to their reset values; the next 8 beats form a complete frame.
- With `FFT_PEAK_THRESH_EN` and `peak_thresh=10`: frame with max 9 → `peak_found=0`; frame with max 10 → `peak_found=1`.
